instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage sitting directly upstream of the instruction memory (IM).
//  Holds the PC, issues one-word read requests to the IM and presents each returned word to decode.
//  Handles the IM's 1-cycle read latency, decode back-pressure, branch/jump redirect and start/halt control.
//  Reads only; the IM write port is tied off here and belongs to the program loader.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset; byte address, bits [1:0] must be 0
//  ADDR_W    10             IM word-address width; IM depth = 2**ADDR_W words
// PORTS
//  clk           in   1       clock; all state updates on posedge
//  rst           in   1       asynchronous, active-low reset
//  start         in   1       pulse: IDLE/HALT -> RUN
//  halt_req      in   1       pulse: RUN -> HALT
//  redirect      in   1       branch/jump taken this cycle; flush the fetch stage
//  redirect_pc   in   32      target byte address; bits [1:0] are ignored
//  im_out        in   32      IM read data; valid the cycle after im_read was asserted
//  im_enable     out  1       IM enable; equals issue
//  im_read       out  1       IM read strobe; equals issue
//  im_write      out  1       constant 0
//  im_in         out  32      constant 0
//  im_address    out  ADDR_W  pc[ADDR_W+1:2]
//  instr_valid   out  1       instr_out/instr_pc are valid for decode
//  instr_ready   in   1       decode accepts this cycle
//  instr_out     out  32      instruction word; equals im_out
//  instr_pc      out  32      byte PC of instr_out
//  fetch_count   out  32      count of accepted instructions; wraps at 2**32
// BEHAVIOUR
//  Reset (asynchronous, rst==0), effective immediately:
//    state=IDLE; pc=RESET_PC; pend=0; pend_pc=RESET_PC; fetch_count=0.
//    As a result im_enable=im_read=0 and instr_valid=0.
//  States:
//    IDLE  -> RUN on start.
//    RUN   -> HALT on halt_req. halt_req wins over start when both are high.
//    HALT  -> RUN on start; fetch resumes at the held pc.
//  Combinational outputs:
//    issue       = (state==RUN) & ~halt_req & ~redirect & (~pend | instr_ready).
//    instr_valid = pend & ~redirect.
//    instr_out   = im_out.
//    instr_pc    = pend_pc.
//  Handshake rules:
//    An instruction transfers when instr_valid & instr_ready.
//    While stalled, no read is issued, so the IM holds im_out and instr_valid stays high.
//  Sequential update, in priority order:
//    1. redirect: pc <= {redirect_pc[31:2],2'b00}; pend <= 0. Any pending word is dropped and not counted.
//       redirect acts in every state and does not change state.
//    2. issue: pend <= 1; pend_pc <= pc; pc <= pc + 4.
//    3. else, if pend & instr_ready: pend <= 0.
//    fetch_count increments on every transfer.
//  Latency and throughput:
//    Issue in cycle k gives instr_valid in cycle k+1.
//    With instr_ready held high, throughput is 1 instruction per cycle.
//    Redirect in cycle k: target is issued in k+1 and valid in k+2.
//  Halt: no new issue. A word already pending is still delivered and handshaked.
//  Wrap-around:
//    pc wraps modulo 2**32.
//    im_address wraps modulo 2**ADDR_W, so the word after the last IM word is word 0.
//  Reset mid-operation: the pending word is discarded; the first issue after start is at RESET_PC.
//  Integration: the top level must drive IM reset with its polarity from rst; that inversion is not done here.
// TESTING
//  1. Reset, start, ready=1, IM[i]=i+100:
//     instr_out 100,101,102... with instr_pc 0,4,8...; fetch_count=4 after 4 transfers.
//  2. Back-pressure: ready=0 for 3 cycles while valid:
//     im_read=0, instr_out/instr_pc held, fetch_count frozen; resumes with no loss or duplication.
//  3. Redirect to 32'h0000_0043 while a word is pending:
//     that word is dropped, one bubble, next instr_pc=32'h40 with data IM[16].
//  4. pc=32'hFFC (ADDR_W=10), ready=1:
//     instr_pc 32'hFFC then 32'h1000; im_address 1023 then 0.
//  5. halt_req while pending and ready=0:
//     no new issue; after ready=1 the word transfers and valid drops.
//     start resumes at the next pc.
//  6. rst low mid-stream:
//     instr_valid=0 and im_read=0 immediately; after release and start, first instr_pc=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage in front of a 1-cycle-latency instruction memory: owns the PC, issues
// one-word reads, and hands each returned word to decode under a valid/ready handshake.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt_req,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    input  logic [31:0]       im_out,
    output logic              im_enable,
    output logic              im_read,
    output logic              im_write,
    output logic [31:0]       im_in,
    output logic [ADDR_W-1:0] im_address,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr_out,
    output logic [31:0]       instr_pc,
    output logic [31:0]       fetch_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic        r_pend;
    logic [31:0] r_pend_pc;
    logic [31:0] r_fetch_count;

    logic        w_issue;
    logic        w_transfer;
    logic [31:0] w_redirect_pc;

    // A new read is only issued when the slot is free or being drained this cycle,
    // so a stalled word stays on im_out untouched.
    assign w_issue       = (r_state == ST_RUN) & ~halt_req & ~redirect & (~r_pend | instr_ready);
    assign w_transfer    = instr_valid & instr_ready;
    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};

    assign im_enable   = w_issue;
    assign im_read     = w_issue;
    assign im_write    = 1'b0;
    assign im_in       = 32'h0000_0000;
    assign im_address  = r_pc[ADDR_W+1:2];

    assign instr_valid = r_pend & ~redirect;
    assign instr_out   = im_out;
    assign instr_pc    = r_pend_pc;
    assign fetch_count = r_fetch_count;

    // halt_req is tested before start so it wins when both arrive together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (start)    r_state <= ST_RUN;
                ST_RUN:  if (halt_req) r_state <= ST_HALT;
                ST_HALT: if (start)    r_state <= ST_RUN;
                default:               r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc      <= RESET_PC;
            r_pend    <= 1'b0;
            r_pend_pc <= RESET_PC;
        end else if (redirect) begin
            r_pc   <= w_redirect_pc;
            r_pend <= 1'b0;
        end else if (w_issue) begin
            r_pend    <= 1'b1;
            r_pend_pc <= r_pc;
            r_pc      <= r_pc + 32'd4;
        end else if (r_pend & instr_ready) begin
            r_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_count <= 32'd0;
        end else if (w_transfer) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural 1-cycle-latency IM holding IM[i]=i+100.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        halt_req;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] im_out;
   logic        im_enable;
   logic        im_read;
   logic        im_write;
   logic [31:0] im_in;
   logic [9:0]  im_address;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
   logic [31:0] fetch_count;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] mem [0:1023];

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(10)) dut (
      .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
      .redirect(redirect), .redirect_pc(redirect_pc), .im_out(im_out),
      .im_enable(im_enable), .im_read(im_read), .im_write(im_write),
      .im_in(im_in), .im_address(im_address), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .instr_out(instr_out), .instr_pc(instr_pc),
      .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   // Instruction memory model: data appears the cycle after a read and is held otherwise.
   initial im_out = 32'd0;
   always @(posedge clk) begin
      if (im_enable && im_read) im_out <= mem[im_address];
   end

   // Advance to just after the next rising edge; inputs are then set and outputs read mid-cycle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; halt_req = 1'b0; redirect = 1'b0;
      redirect_pc = 32'd0; instr_ready = 1'b1;
      #3;
      vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got=%0b exp=0", instr_valid); end
      vectors++; if (im_read !== 1'b0 || im_enable !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_read got=%0b/%0b exp=0/0", im_read, im_enable); end
      vectors++; if (fetch_count !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_count got=%0d exp=0", fetch_count); end
      vectors++; if (im_write !== 1'b0 || im_in !== 32'd0) begin miscompares++; $display("[TB] FAIL tieoff got=%0b/%h exp=0/0", im_write, im_in); end
      vectors++; if (instr_pc !== 32'd0 || im_address !== 10'd0) begin miscompares++; $display("[TB] FAIL reset_pc got=%h/%0d exp=0/0", instr_pc, im_address); end
      step();
      rst = 1'b1;
      step();
      #1;
      vectors++; if (im_read !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_no_issue got=%0b exp=0", im_read); end
   endtask

   task automatic test_stream();
      start = 1'b1;
      #1;
      vectors++; if (im_read !== 1'b0) begin miscompares++; $display("[TB] FAIL start_cycle_read got=%0b exp=0", im_read); end
      step();
      start = 1'b0;
      #1;
      vectors++; if (im_read !== 1'b1 || im_address !== 10'd0) begin miscompares++; $display("[TB] FAIL first_issue got=%0b@%0d exp=1@0", im_read, im_address); end
      for (int i = 0; i < 4; i++) begin
         step();
         #1;
         vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL stream_valid[%0d] got=%0b exp=1", i, instr_valid); end
         vectors++; if (instr_out !== 32'd100 + i) begin miscompares++; $display("[TB] FAIL stream_data[%0d] got=%0d exp=%0d", i, instr_out, 100 + i); end
         vectors++; if (instr_pc !== 32'(4 * i)) begin miscompares++; $display("[TB] FAIL stream_pc[%0d] got=%h exp=%h", i, instr_pc, 4 * i); end
         vectors++; if (fetch_count !== 32'(i)) begin miscompares++; $display("[TB] FAIL stream_count[%0d] got=%0d exp=%0d", i, fetch_count, i); end
      end
   endtask

   task automatic test_backpressure();
      step();
      for (int i = 0; i < 3; i++) begin
         instr_ready = 1'b0;
         #1;
         vectors++; if (im_read !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_read[%0d] got=%0b exp=0", i, im_read); end
         vectors++; if (instr_valid !== 1'b1 || instr_out !== 32'd104 || instr_pc !== 32'd16) begin miscompares++; $display("[TB] FAIL stall_hold[%0d] got=%0b/%0d/%h exp=1/104/10", i, instr_valid, instr_out, instr_pc); end
         vectors++; if (fetch_count !== 32'd4) begin miscompares++; $display("[TB] FAIL stall_count[%0d] got=%0d exp=4", i, fetch_count); end
         step();
      end
      instr_ready = 1'b1;
      #1;
      vectors++; if (instr_out !== 32'd104 || im_read !== 1'b1 || im_address !== 10'd5) begin miscompares++; $display("[TB] FAIL resume got=%0d/%0b@%0d exp=104/1@5", instr_out, im_read, im_address); end
      step();
      #1;
      vectors++; if (instr_out !== 32'd105 || instr_pc !== 32'd20 || fetch_count !== 32'd5) begin miscompares++; $display("[TB] FAIL after_stall got=%0d/%h/%0d exp=105/14/5", instr_out, instr_pc, fetch_count); end
   endtask

   task automatic test_redirect();
      redirect = 1'b1; redirect_pc = 32'h0000_0043;
      #1;
      vectors++; if (instr_valid !== 1'b0 || im_read !== 1'b0) begin miscompares++; $display("[TB] FAIL redir_cycle got=%0b/%0b exp=0/0", instr_valid, im_read); end
      step();
      redirect = 1'b0;
      #1;
      vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL redir_bubble got=%0b exp=0", instr_valid); end
      vectors++; if (im_read !== 1'b1 || im_address !== 10'd16) begin miscompares++; $display("[TB] FAIL redir_issue got=%0b@%0d exp=1@16", im_read, im_address); end
      vectors++; if (fetch_count !== 32'd5) begin miscompares++; $display("[TB] FAIL redir_drop_count got=%0d exp=5", fetch_count); end
      step();
      #1;
      vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr_out !== 32'd116) begin miscompares++; $display("[TB] FAIL redir_target got=%0b/%h/%0d exp=1/40/116", instr_valid, instr_pc, instr_out); end
   endtask

   task automatic test_wrap();
      redirect = 1'b1; redirect_pc = 32'h0000_0FFC;
      step();
      redirect = 1'b0;
      #1;
      vectors++; if (im_address !== 10'd1023) begin miscompares++; $display("[TB] FAIL wrap_addr_hi got=%0d exp=1023", im_address); end
      step();
      #1;
      vectors++; if (instr_pc !== 32'hFFC || instr_out !== 32'd1123) begin miscompares++; $display("[TB] FAIL wrap_last got=%h/%0d exp=ffc/1123", instr_pc, instr_out); end
      vectors++; if (im_address !== 10'd0) begin miscompares++; $display("[TB] FAIL wrap_addr_lo got=%0d exp=0", im_address); end
      step();
      #1;
      vectors++; if (instr_pc !== 32'h1000 || instr_out !== 32'd100 || fetch_count !== 32'd6) begin miscompares++; $display("[TB] FAIL wrap_first got=%h/%0d/%0d exp=1000/100/6", instr_pc, instr_out, fetch_count); end
   endtask

   task automatic test_halt();
      halt_req = 1'b1; instr_ready = 1'b0;
      #1;
      vectors++; if (im_read !== 1'b0) begin miscompares++; $display("[TB] FAIL halt_no_issue got=%0b exp=0", im_read); end
      step();
      halt_req = 1'b0;
      #1;
      vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h1000 || im_read !== 1'b0) begin miscompares++; $display("[TB] FAIL halt_hold got=%0b/%h/%0b exp=1/1000/0", instr_valid, instr_pc, im_read); end
      step();
      instr_ready = 1'b1;
      #1;
      vectors++; if (instr_valid !== 1'b1 || im_read !== 1'b0) begin miscompares++; $display("[TB] FAIL halt_drain got=%0b/%0b exp=1/0", instr_valid, im_read); end
      step();
      #1;
      vectors++; if (instr_valid !== 1'b0 || fetch_count !== 32'd7) begin miscompares++; $display("[TB] FAIL halt_drained got=%0b/%0d exp=0/7", instr_valid, fetch_count); end
      start = 1'b1;
      step();
      start = 1'b0;
      #1;
      vectors++; if (im_read !== 1'b1 || im_address !== 10'd1) begin miscompares++; $display("[TB] FAIL halt_resume got=%0b@%0d exp=1@1", im_read, im_address); end
      step();
      #1;
      vectors++; if (instr_pc !== 32'h1004 || instr_out !== 32'd101) begin miscompares++; $display("[TB] FAIL halt_resume_data got=%h/%0d exp=1004/101", instr_pc, instr_out); end
   endtask

   task automatic test_reset_midstream();
      #1;
      rst = 1'b0;
      #1;
      vectors++; if (instr_valid !== 1'b0 || im_read !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_reset got=%0b/%0b exp=0/0", instr_valid, im_read); end
      vectors++; if (fetch_count !== 32'd0) begin miscompares++; $display("[TB] FAIL mid_reset_count got=%0d exp=0", fetch_count); end
      step();
      rst = 1'b1;
      step();
      start = 1'b1;
      #1;
      vectors++; if (im_read !== 1'b0) begin miscompares++; $display("[TB] FAIL post_reset_idle got=%0b exp=0", im_read); end
      step();
      start = 1'b0;
      step();
      #1;
      vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'd0 || instr_out !== 32'd100) begin miscompares++; $display("[TB] FAIL post_reset_first got=%0b/%h/%0d exp=1/0/100", instr_valid, instr_pc, instr_out); end
      step();
      #1;
      vectors++; if (fetch_count !== 32'd1 || instr_pc !== 32'd4) begin miscompares++; $display("[TB] FAIL post_reset_count got=%0d/%h exp=1/4", fetch_count, instr_pc); end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'(i + 100);
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_halt();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
